// File: rtl/ir_nec_rx.sv
// NEC infrared frame receiver: synchronises the raw IR line, times marks and spaces,
// and decodes 32-bit frames and repeat codes into registered one-cycle flags.
//
// state     | meaning
// IDLE      | waiting for a mark to begin
// HDR_MARK  | timing the 9 ms leader mark
// HDR_SPACE | timing the leader space (4.5 ms frame / 2.25 ms repeat)
// BIT_MARK  | timing a 562.5 us bit (or stop) mark
// BIT_SPACE | timing a bit space; its length carries the bit value
// RPT_MARK  | timing the trailing mark of a repeat code
module ir_nec_rx #(
  parameter int UNIT_CYC  = 28125,
  parameter int TOL_SHIFT = 2,
  parameter int ADDR_EXT  = 1,
  parameter int CHK_INV   = 1,
  parameter int TIMEOUT_U = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iir,
  output logic [15:0] iraddr,
  output logic [15:0] irdata,
  output logic        get_flag,
  output logic        repeat_flag,
  output logic        err_flag,
  output logic        busy
);

  localparam int CNT_MAX = (TIMEOUT_U + 1) * UNIT_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [31:0] TO_CYC = 32'(TIMEOUT_U * UNIT_CYC);

  typedef enum logic [2:0] {
    IDLE, HDR_MARK, HDR_SPACE, BIT_MARK, BIT_SPACE, RPT_MARK
  } state_t;

  state_t        state, state_n;
  logic          s1, s2, s3;
  logic          rise_r, fall_r;
  logic [CW-1:0] cnt;
  logic [5:0]    idx, idx_n;
  logic [31:0]   sr, sr_n;
  logic          frame_ok, ok_n;
  logic          get_n, rpt_n, err_n, load;
  logic [31:0]   dur;
  logic          tmo, chk_ok;
  logic          m1, m3, m4, m8, m16;

  function automatic logic near(input logic [31:0] d, input int nom);
    logic [31:0] n;
    logic [31:0] tol;
    n   = 32'(nom);
    tol = n >> TOL_SHIFT;
    return (d + tol >= n) && (d <= n + tol);
  endfunction

  // The counter restarts at the edge cycle, so the elapsed time is cnt + 1.
  assign dur = 32'(cnt) + 32'd1;
  assign tmo = (32'(cnt) >= TO_CYC);
  assign m1  = near(dur, UNIT_CYC);
  assign m3  = near(dur, 3 * UNIT_CYC);
  assign m4  = near(dur, 4 * UNIT_CYC);
  assign m8  = near(dur, 8 * UNIT_CYC);
  assign m16 = near(dur, 16 * UNIT_CYC);

  assign chk_ok = ((ADDR_EXT != 0) || (sr[15:8] == ~sr[7:0])) &&
                  ((CHK_INV == 0) || (sr[31:24] == ~sr[23:16]));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      s1     <= iir;
      s2     <= s1;
      s3     <= s2;
      rise_r <= s2 & ~s3;
      fall_r <= ~s2 & s3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (rise_r || fall_r || state == IDLE) begin
      cnt <= '0;
    end else if (cnt != CW'(CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      sr          <= '0;
      frame_ok    <= 1'b0;
      iraddr      <= '0;
      irdata      <= '0;
      get_flag    <= 1'b0;
      repeat_flag <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      sr          <= sr_n;
      frame_ok    <= ok_n;
      get_flag    <= get_n;
      repeat_flag <= rpt_n;
      err_flag    <= err_n;
      if (load) begin
        iraddr <= sr[15:0];
        irdata <= sr[31:16];
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    sr_n    = sr;
    ok_n    = frame_ok;
    get_n   = 1'b0;
    rpt_n   = 1'b0;
    err_n   = 1'b0;
    load    = 1'b0;
    // Timeout wins over any edge seen in the same cycle.
    if (tmo && (state == BIT_MARK || state == BIT_SPACE || state == RPT_MARK)) begin
      err_n   = 1'b1;
      ok_n    = 1'b0;
      state_n = IDLE;
    end else if (tmo && (state == HDR_MARK || state == HDR_SPACE)) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (fall_r) state_n = HDR_MARK;
        HDR_MARK: if (rise_r) state_n = m16 ? HDR_SPACE : IDLE;
        HDR_SPACE:
          if (fall_r) begin
            if (m8) begin
              state_n = BIT_MARK;
              idx_n   = '0;
              sr_n    = '0;
            end else if (m4) begin
              state_n = RPT_MARK;
            end else begin
              state_n = IDLE;
            end
          end
        BIT_MARK:
          if (rise_r) begin
            if (!m1) begin
              err_n   = 1'b1;
              ok_n    = 1'b0;
              state_n = IDLE;
            end else if (idx < 6'd32) begin
              state_n = BIT_SPACE;
            end else begin
              state_n = IDLE;
              if (chk_ok) begin
                load  = 1'b1;
                get_n = 1'b1;
                ok_n  = 1'b1;
              end else begin
                err_n = 1'b1;
                ok_n  = 1'b0;
              end
            end
          end
        BIT_SPACE:
          if (fall_r) begin
            if (m1 || m3) begin
              sr_n    = {m3, sr[31:1]};
              idx_n   = idx + 6'd1;
              state_n = BIT_MARK;
            end else begin
              err_n   = 1'b1;
              ok_n    = 1'b0;
              state_n = IDLE;
            end
          end
        RPT_MARK:
          if (rise_r) begin
            state_n = IDLE;
            if (m1) begin
              rpt_n = frame_ok;
            end else begin
              err_n = 1'b1;
              ok_n  = 1'b0;
            end
          end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_nec_rx.sv
// Directed bench for ir_nec_rx with a 100-cycle unit: frames, repeats, corrupted
// frames, timing boundaries, timeout and mid-frame reset.
module tb_ir_nec_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iir = 1'b1;
  logic [15:0] iraddr, irdata;
  logic        get_flag, repeat_flag, err_flag, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_get = 0;
  int n_rpt = 0;
  int n_err = 0;
  int g0, r0, e0;

  always #5 clk = ~clk;

  ir_nec_rx #(
    .UNIT_CYC(100), .TOL_SHIFT(2), .ADDR_EXT(1), .CHK_INV(1), .TIMEOUT_U(32)
  ) dut (
    .clk(clk), .rst(rst), .iir(iir), .iraddr(iraddr), .irdata(irdata),
    .get_flag(get_flag), .repeat_flag(repeat_flag), .err_flag(err_flag), .busy(busy)
  );

  always @(negedge clk) begin
    if (get_flag) n_get++;
    if (repeat_flag) n_rpt++;
    if (err_flag) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    iir = v;
    repeat (n) @(negedge clk);
  endtask

  // sp_bit selects one bit whose mark/space length is overridden (sp_space 0 = normal);
  // stop_at ends transmission just before that bit's mark.
  task automatic send(input logic [31:0] w, input int sp_bit, input int sp_mark,
                      input int sp_space, input int stop_at);
    hold(1'b0, 1600);
    hold(1'b1, 800);
    for (int i = 0; i < 32; i++) begin
      if (i == stop_at) return;
      hold(1'b0, (i == sp_bit) ? sp_mark : 100);
      hold(1'b1, (i == sp_bit && sp_space != 0) ? sp_space : (w[i] ? 300 : 100));
    end
    hold(1'b0, 100);
    iir = 1'b1;
  endtask

  task automatic send_repeat();
    hold(1'b0, 1600);
    hold(1'b1, 400);
    hold(1'b0, 100);
    iir = 1'b1;
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_iraddr", 32'(iraddr), 32'h0);
    chk("rst_irdata", 32'(irdata), 32'h0);
    chk("rst_flags", {29'd0, get_flag, repeat_flag, err_flag}, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    hold(1'b1, 20);

    // Good frame and output latency
    g0 = n_get; e0 = n_err;
    send({16'hBA45, 16'h00FF}, -1, 0, 0, -1);
    repeat (3) @(posedge clk);
    #1 chk("lat_get_early", 32'(get_flag), 32'h0);
    @(posedge clk);
    #1 chk("lat_get_4clk", 32'(get_flag), 32'h1);
    chk("a_iraddr", 32'(iraddr), 32'h00FF);
    chk("a_irdata", 32'(irdata), 32'hBA45);
    hold(1'b1, 50);
    chk("a_get_cnt", n_get - g0, 1);
    chk("a_err_cnt", n_err - e0, 0);

    // Repeat code after a good frame
    r0 = n_rpt; g0 = n_get;
    send_repeat();
    hold(1'b1, 50);
    chk("rpt_cnt", n_rpt - r0, 1);
    chk("rpt_get_cnt", n_get - g0, 0);
    chk("rpt_irdata", 32'(irdata), 32'hBA45);

    // Failed data inverse check; a later repeat must be ignored
    g0 = n_get; e0 = n_err;
    send({16'h4545, 16'h0000}, -1, 0, 0, -1);
    hold(1'b1, 50);
    chk("inv_err_cnt", n_err - e0, 1);
    chk("inv_get_cnt", n_get - g0, 0);
    chk("inv_iraddr", 32'(iraddr), 32'h00FF);
    chk("inv_irdata", 32'(irdata), 32'hBA45);
    r0 = n_rpt; e0 = n_err;
    send_repeat();
    hold(1'b1, 50);
    chk("rpt_after_err", n_rpt - r0, 0);
    chk("rpt_after_err_e", n_err - e0, 0);

    // Two-unit space at bit 10
    g0 = n_get; e0 = n_err;
    send({16'hE817, 16'h1234}, 10, 100, 200, 12);
    hold(1'b1, 50);
    chk("sp2_err_cnt", n_err - e0, 1);
    chk("sp2_get_cnt", n_get - g0, 0);

    // 125-cycle mark accepted; clean decode after the error
    g0 = n_get; e0 = n_err;
    send({16'h7F80, 16'hA55A}, 5, 125, 0, -1);
    hold(1'b1, 50);
    chk("m125_get_cnt", n_get - g0, 1);
    chk("m125_err_cnt", n_err - e0, 0);
    chk("m125_iraddr", 32'(iraddr), 32'hA55A);
    chk("m125_irdata", 32'(irdata), 32'h7F80);

    // 126-cycle mark rejected
    g0 = n_get; e0 = n_err;
    send({16'h6699, 16'h0001}, 5, 126, 0, 7);
    hold(1'b1, 50);
    chk("m126_err_cnt", n_err - e0, 1);
    chk("m126_get_cnt", n_get - g0, 0);
    chk("m126_irdata", 32'(irdata), 32'h7F80);

    // Short leader mark: silent return to idle
    e0 = n_err;
    hold(1'b0, 1199);
    hold(1'b1, 10);
    chk("hdr_busy", 32'(busy), 32'h0);
    hold(1'b1, 40);
    chk("hdr_err_cnt", n_err - e0, 0);

    // Line stuck idle in a bit space: timeout after 32 units
    e0 = n_err;
    hold(1'b0, 1600);
    hold(1'b1, 800);
    hold(1'b0, 100);
    hold(1'b1, 3100);
    chk("to_busy_before", 32'(busy), 32'h1);
    chk("to_err_before", n_err - e0, 0);
    hold(1'b1, 200);
    chk("to_err_cnt", n_err - e0, 1);
    chk("to_busy_after", 32'(busy), 32'h0);

    // Reset in the middle of a frame
    g0 = n_get; e0 = n_err; r0 = n_rpt;
    send({16'hF708, 16'h0001}, -1, 0, 0, 20);
    rst = 1'b0;
    hold(1'b1, 5);
    chk("mrst_iraddr", 32'(iraddr), 32'h0);
    chk("mrst_irdata", 32'(irdata), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    hold(1'b1, 20);
    chk("mrst_flags", (n_get - g0) + (n_err - e0) + (n_rpt - r0), 0);
    g0 = n_get;
    send({16'hF708, 16'h0001}, -1, 0, 0, -1);
    hold(1'b1, 50);
    chk("post_get_cnt", n_get - g0, 1);
    chk("post_iraddr", 32'(iraddr), 32'h0001);
    chk("post_irdata", 32'(irdata), 32'hF708);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
